prio_encoder_rr: RTL

Parametrised, registered N-to-log2(N) encoder with sticky request capture, selectable fixed-priority or round-robin arbitration, and a valid/ready output handshake. Requests on d are latched into a pending mask while en is high. One index is issued per accepted handshake until the mask drains. It replaces the combinational one-hot encoders wherever multiple simultaneous or back-to-back requests must each be encoded exactly once.

---
 rtl/prio_encoder_rr_pkg.sv | 20 ++
 rtl/prio_encoder_rr_pick.sv | 23 ++
 rtl/prio_encoder_rr.sv | 115 +++++++++++
 3 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the registered priority / round-robin encoder:
// arbitration mode encodings, index-width helper and one-hot builder.
package enc_pkg;

  localparam int FIXED_PRIO  = 0;
  localparam int ROUND_ROBIN = 1;
  localparam int MAX_N       = 1024;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot_of(input int idx, input int n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// Combinational highest-set-bit finder: returns the index of the top set
// bit of i_vec and whether any bit is set.
module prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx = W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-index encoder with sticky request capture, fixed-priority
// or round-robin selection, and a valid/ready output handshake.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int RR_MODE = FIXED_PRIO
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N-1:0]              d,
  output logic [idx_width(N)-1:0]   o,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic                      busy,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int W = idx_width(N);

  logic [N-1:0] r_pend;
  logic [W-1:0] r_o;
  logic         r_valid;
  logic         r_ovf;

  logic [W-1:0] w_sel;
  logic         w_any;
  logic         w_ld;
  logic [N-1:0] w_ld_mask;
  logic [N-1:0] w_cap;
  logic [N-1:0] w_pend_nxt;
  logic         w_ovf_set;

  generate
    if (RR_MODE == ROUND_ROBIN) begin : g_rr
      logic [W-1:0] r_ptr;
      logic [N-1:0] w_above;
      logic [N-1:0] w_rev_above;
      logic [N-1:0] w_rev_all;
      logic [W-1:0] w_idx_above;
      logic [W-1:0] w_idx_all;
      logic         w_hit_above;
      logic         w_hit_all;

      // Bit-reversal turns "highest set" into "lowest set", so each picker
      // finds the first pending index scanning upward.
      for (genvar g = 0; g < N; g++) begin : g_bits
        assign w_above[g]     = r_pend[g] && (W'(g) > r_ptr);
        assign w_rev_above[g] = w_above[N-1-g];
        assign w_rev_all[g]   = r_pend[N-1-g];
      end

      prio_pick #(.N(N), .W(W)) u_pick_above (
        .i_vec (w_rev_above),
        .o_idx (w_idx_above),
        .o_any (w_hit_above)
      );

      prio_pick #(.N(N), .W(W)) u_pick_wrap (
        .i_vec (w_rev_all),
        .o_idx (w_idx_all),
        .o_any (w_hit_all)
      );

      assign w_any = w_hit_all;
      assign w_sel = w_hit_above ? (W'(N-1) - w_idx_above)
                                 : (W'(N-1) - w_idx_all);

      always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_ptr <= W'(N-1);
        else if (w_ld) r_ptr <= w_sel;
      end
    end else begin : g_fixed
      prio_pick #(.N(N), .W(W)) u_pick (
        .i_vec (r_pend),
        .o_idx (w_sel),
        .o_any (w_any)
      );
    end
  endgenerate

  assign w_ld       = (!r_valid || o_ready) && w_any;
  assign w_ld_mask  = w_ld ? N'(onehot_of(int'(w_sel), N)) : '0;
  assign w_cap      = en ? d : '0;
  // A bit being issued and re-requested on the same edge stays pending.
  assign w_pend_nxt = (r_pend & ~w_ld_mask) | w_cap;
  assign w_ovf_set  = |(w_cap & r_pend & ~w_ld_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= '0;
      r_o     <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_ld) begin
        r_o     <= w_sel;
        r_valid <= 1'b1;
      end else if (r_valid && o_ready) begin
        r_valid <= 1'b0;
      end
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o       = r_o;
  assign o_valid = r_valid;
  assign busy    = w_any || r_valid;
  assign ovf     = r_ovf;

endmodule
